// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with valid/ready handshake, flush and bubble gating.
// Operand forwarding from EX/MEM and MEM/WB is compiled in only when ID_EX_FORWARD_EN is defined.
module id_ex_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_reg1,
    input  logic [31:0] in_reg2,
    input  logic [31:0] in_imm,
    input  logic        in_aluSrc,
    input  logic [3:0]  in_aluCtr,
    input  logic        in_regWrite,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic        in_memToReg,
    input  logic        in_branch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] input1,
    output logic [31:0] input2,
    output logic [3:0]  aluCtr,
    output logic [31:0] out_storeData,
    output logic [4:0]  out_rd,
    output logic        out_regWrite,
    output logic        out_memRead,
    output logic        out_memWrite,
    output logic        out_memToReg,
    output logic        out_branch,
    input  logic        flush,
    input  logic        exmem_regWrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regWrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result
);
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  alu_ctr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
    } entry_t;

    entry_t      ent_q, ent_d, ent_in;
    logic        valid_q, valid_d;
    logic        capture;
    logic [31:0] op_a, op_b;

    assign ent_in = '{in_rs, in_rt, in_rd, in_reg1, in_reg2, in_imm, in_aluSrc, in_aluCtr,
                      in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch};
    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = flush ? 1'b0 : capture ? 1'b1 : out_ready ? 1'b0 : valid_q;
        ent_d   = capture ? ent_in : ent_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded
    always_comb begin
        op_a = (exmem_regWrite && exmem_rd != 5'd0 && exmem_rd == ent_q.rs) ? exmem_result :
               (memwb_regWrite && memwb_rd != 5'd0 && memwb_rd == ent_q.rs) ? memwb_result : ent_q.reg1;
        op_b = (exmem_regWrite && exmem_rd != 5'd0 && exmem_rd == ent_q.rt) ? exmem_result :
               (memwb_regWrite && memwb_rd != 5'd0 && memwb_rd == ent_q.rt) ? memwb_result : ent_q.reg2;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_regWrite, exmem_rd, exmem_result, memwb_regWrite, memwb_rd,
                          memwb_result, ent_q.rs, ent_q.rt};
    assign op_a = ent_q.reg1;
    assign op_b = ent_q.reg2;
`endif

    assign out_valid     = valid_q;
    assign input1        = op_a;
    assign input2        = ent_q.alu_src ? ent_q.imm : op_b;
    assign out_storeData = op_b;
    assign aluCtr        = ent_q.alu_ctr;
    assign out_rd        = ent_q.rd;
    // bubbles must never write state or redirect fetch
    assign out_regWrite  = valid_q && ent_q.reg_write;
    assign out_memRead   = valid_q && ent_q.mem_read;
    assign out_memWrite  = valid_q && ent_q.mem_write;
    assign out_branch    = valid_q && ent_q.branch;
    assign out_memToReg  = ent_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg; expectations follow ID_EX_FORWARD_EN when defined.
module tb_id_ex_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, in_valid, in_ready, in_aluSrc;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [31:0] in_reg1, in_reg2, in_imm;
    logic [3:0]  in_aluCtr;
    logic        in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch;
    logic        out_valid, out_ready;
    logic [31:0] input1, input2, out_storeData;
    logic [3:0]  aluCtr;
    logic [4:0]  out_rd;
    logic        out_regWrite, out_memRead, out_memWrite, out_memToReg, out_branch;
    logic        flush, exmem_regWrite, memwb_regWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] reg1, reg2, imm;
        logic        alusrc;
        logic [3:0]  aluctr;
        logic        rw, mr, mw, m2r, br;
    } ent_t;
    ent_t q[$];

    id_ex_reg dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_imm(in_imm), .in_aluSrc(in_aluSrc), .in_aluCtr(in_aluCtr),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_memToReg(in_memToReg), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready), .input1(input1), .input2(input2),
        .aluCtr(aluCtr), .out_storeData(out_storeData), .out_rd(out_rd),
        .out_regWrite(out_regWrite), .out_memRead(out_memRead), .out_memWrite(out_memWrite),
        .out_memToReg(out_memToReg), .out_branch(out_branch), .flush(flush),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result)
    );

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        logic [31:0] res;
        res = v;
`ifdef ID_EX_FORWARD_EN
        if (r != 5'd0 && memwb_regWrite && memwb_rd == r) res = memwb_result;
        if (r != 5'd0 && exmem_regWrite && exmem_rd == r) res = exmem_result;
`endif
        return res;
    endfunction

    // reference model of the single-entry stage
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) q.delete();
        else if (flush) q.delete();
        else if (in_valid && (q.size() == 0 || out_ready)) begin
            if (q.size() != 0) void'(q.pop_front());
            q.push_back('{in_rs, in_rt, in_rd, in_reg1, in_reg2, in_imm, in_aluSrc, in_aluCtr,
                          in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch});
        end else if (q.size() != 0 && out_ready) void'(q.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic src, input logic [3:0] ctr, input logic [4:0] ctl);
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
        in_reg1 = r1; in_reg2 = r2; in_imm = imm; in_aluSrc = src; in_aluCtr = ctr;
        {in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch} = ctl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        offer(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0);
        {exmem_regWrite, exmem_rd, exmem_result, memwb_regWrite, memwb_rd, memwb_result} = '0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if ({input1, input2, out_storeData} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h %h %h exp=0", input1, input2, out_storeData); end
        checks++; if ({aluCtr, out_rd, out_regWrite, out_memRead, out_memWrite, out_memToReg, out_branch} !== 14'd0) begin failures++; $display("FAIL reset_ctl got=%h %h %b%b%b%b%b exp=0", aluCtr, out_rd, out_regWrite, out_memRead, out_memWrite, out_memToReg, out_branch); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_async_reset();
        @(negedge clk); out_ready = 1'b0;
        offer(1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h0, 1'b0, 4'hA, 5'b10000);
        tick();
        checks++; if (out_valid !== 1'b1 || input1 !== 32'h55) begin failures++; $display("FAIL pre_reset_entry got=%b %h exp=1 00000055", out_valid, input1); end
        @(negedge clk); in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || input1 !== 32'd0 || aluCtr !== 4'd0) begin failures++; $display("FAIL async_reset got=%b %h %h exp=0 0 0", out_valid, input1, aluCtr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", in_ready); end
        @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
        offer(1'b1, 5'd1, 5'd2, 5'd9, 32'h77, 32'h88, 32'h0, 1'b0, 4'h3, 5'b00000);
        tick();
        checks++; if (out_valid !== 1'b1 || input1 !== 32'h77 || out_rd !== 5'd9) begin failures++; $display("FAIL first_after_reset got=%b %h %h exp=1 00000077 09", out_valid, input1, out_rd); end
        @(negedge clk); in_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        @(negedge clk); out_ready = 1'b1;
        offer(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 5'b10000);
        tick();
        checks++; if (out_valid !== 1'b1 || input1 !== 32'd5 || input2 !== 32'd7) begin failures++; $display("FAIL basic_ops got=%b %h %h exp=1 5 7", out_valid, input1, input2); end
        checks++; if (aluCtr !== 4'b0010 || out_regWrite !== 1'b1 || out_rd !== 5'd4) begin failures++; $display("FAIL basic_ctl got=%b %b %h exp=0010 1 04", aluCtr, out_regWrite, out_rd); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_regWrite !== 1'b0) begin failures++; $display("FAIL bubble_gate got=%b %b exp=0 0", out_valid, out_regWrite); end
    endtask

    task automatic test_imm();
        @(negedge clk);
        offer(1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 32'd9, 32'hFFFF_FFFC, 1'b1, 4'b0010, 5'b00100);
        tick();
        checks++; if (input2 !== 32'hFFFF_FFFC || out_storeData !== 32'd9) begin failures++; $display("FAIL imm_sel got=%h %h exp=fffffffc 00000009", input2, out_storeData); end
        checks++; if (out_memWrite !== 1'b1 || input1 !== 32'd3) begin failures++; $display("FAIL imm_store got=%b %h exp=1 00000003", out_memWrite, input1); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_memWrite !== 1'b0) begin failures++; $display("FAIL store_bubble got=%b exp=0", out_memWrite); end
    endtask

    task automatic test_stall();
        @(negedge clk); out_ready = 1'b0;
        offer(1'b1, 5'd1, 5'd2, 5'd5, 32'hA1, 32'hA2, 32'd0, 1'b0, 4'h1, 5'b10000);
        tick();
        @(negedge clk);
        offer(1'b1, 5'd3, 5'd4, 5'd7, 32'hB2, 32'hB3, 32'd0, 1'b0, 4'h4, 5'b10000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || input1 !== 32'hA1 || out_rd !== 5'd5 || aluCtr !== 4'h1) begin failures++; $display("FAIL stall_hold%0d got=%b %h %h %h exp=0 000000a1 05 1", i, in_ready, input1, out_rd, aluCtr); end
        end
        @(negedge clk); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || input1 !== 32'hB2 || out_rd !== 5'd7) begin failures++; $display("FAIL stall_second got=%b %h %h exp=1 000000b2 07", out_valid, input1, out_rd); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk); out_ready = 1'b0;
        offer(1'b1, 5'd1, 5'd2, 5'd8, 32'hC1, 32'hC2, 32'd0, 1'b0, 4'h2, 5'b10000);
        tick();
        @(negedge clk); flush = 1'b1;
        offer(1'b1, 5'd1, 5'd2, 5'd9, 32'hD1, 32'hD2, 32'd0, 1'b0, 4'h2, 5'b10000);
        tick();
        checks++; if (out_valid !== 1'b0 || out_regWrite !== 1'b0) begin failures++; $display("FAIL flush got=%b %b exp=0 0", out_valid, out_regWrite); end
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
    endtask

    task automatic test_forward();
        logic [31:0] exp;
        @(negedge clk); out_ready = 1'b0;
        offer(1'b1, 5'd3, 5'd3, 5'd1, 32'h100, 32'h200, 32'h0, 1'b0, 4'h2, 5'b00100);
        {exmem_regWrite, exmem_rd, exmem_result} = {1'b1, 5'd3, 32'h11};
        {memwb_regWrite, memwb_rd, memwb_result} = {1'b1, 5'd3, 32'h22};
        tick();
        exp = fwd(5'd3, 32'h100);
        checks++; if (input1 !== exp) begin failures++; $display("FAIL fwd_exmem got=%h exp=%h", input1, exp); end
        exp = fwd(5'd3, 32'h200);
        checks++; if (out_storeData !== exp || input2 !== exp) begin failures++; $display("FAIL fwd_opb got=%h %h exp=%h", input2, out_storeData, exp); end
        @(negedge clk); exmem_rd = 5'd0;
        #1;
        exp = fwd(5'd3, 32'h100);
        checks++; if (input1 !== exp) begin failures++; $display("FAIL fwd_memwb got=%h exp=%h", input1, exp); end
        @(negedge clk); out_ready = 1'b1; memwb_rd = 5'd0;
        offer(1'b1, 5'd0, 5'd0, 5'd1, 32'h300, 32'h400, 32'h0, 1'b0, 4'h2, 5'b00000);
        tick();
        checks++; if (input1 !== 32'h300 || input2 !== 32'h400) begin failures++; $display("FAIL fwd_r0 got=%h %h exp=00000300 00000400", input1, input2); end
        @(negedge clk); in_valid = 1'b0;
        {exmem_regWrite, memwb_regWrite} = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            offer($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), 5'($urandom));
            {exmem_regWrite, exmem_rd, exmem_result} = {1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)};
            {memwb_regWrite, memwb_rd, memwb_result} = {1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)};
            tick();
            checks++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() == 0 || out_ready)) begin failures++; $display("FAIL b2b_hs%0d got=%b %b exp=%b %b", i, out_valid, in_ready, q.size() != 0, q.size() == 0 || out_ready); end
            if (q.size() != 0) begin
                checks++; if (input1 !== fwd(q[0].rs, q[0].reg1) || out_storeData !== fwd(q[0].rt, q[0].reg2) || input2 !== (q[0].alusrc ? q[0].imm : fwd(q[0].rt, q[0].reg2))) begin failures++; $display("FAIL b2b_ops%0d got=%h %h %h exp=%h %h", i, input1, input2, out_storeData, fwd(q[0].rs, q[0].reg1), fwd(q[0].rt, q[0].reg2)); end
                checks++; if ({aluCtr, out_rd, out_regWrite, out_memRead, out_memWrite, out_memToReg, out_branch} !== {q[0].aluctr, q[0].rd, q[0].rw, q[0].mr, q[0].mw, q[0].m2r, q[0].br}) begin failures++; $display("FAIL b2b_ctl%0d got=%h %h %b%b%b%b%b exp=%h %h %b%b%b%b%b", i, aluCtr, out_rd, out_regWrite, out_memRead, out_memWrite, out_memToReg, out_branch, q[0].aluctr, q[0].rd, q[0].rw, q[0].mr, q[0].mw, q[0].m2r, q[0].br); end
            end else begin
                checks++; if ({out_regWrite, out_memRead, out_memWrite, out_branch} !== 4'b0) begin failures++; $display("FAIL b2b_bubble%0d got=%b%b%b%b exp=0000", i, out_regWrite, out_memRead, out_memWrite, out_branch); end
            end
        end
        @(negedge clk); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_basic();
        test_imm();
        test_stall();
        test_flush();
        test_forward();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
